// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
// Contents: FSM state enum, clog2 and derived-width functions.
package rr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Owner index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

  // Hold counter width; MAX_HOLD=0 still needs one bit of storage.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (clog2(max_hold + 1) < 1) ? 1 : clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_bus_arbiter_if.sv
// Requester-side bus bundle for the round-robin arbiter.
// master: requesters drive req/data_in and observe the grant.
// slave : arbiter consumes req/data_in and drives gnt, gnt_id, bus_valid, bus_out.
interface rr_bus_arbiter_if
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  localparam int unsigned IDW = id_width(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id;
  logic               bus_valid;
  logic [DW-1:0]      bus_out;

  modport master (output req, data_in, input gnt, gnt_id, bus_valid, bus_out);
  modport slave  (input req, data_in, output gnt, gnt_id, bus_valid, bus_out);
endinterface

// File: rtl/rr_bus_arbiter_mux.sv
// aoi_grant_mux: AND-OR data steering built from AOI22 pairs and a NAND merge.
// Ports: d (NREQ*DW slices), g (one-hot or zero grant), y (selected slice, 0 if none).
module aoi_grant_mux #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
) (
  input  logic [NREQ*DW-1:0] d,
  input  logic [NREQ-1:0]    g,
  output logic [DW-1:0]      y
);
  localparam int unsigned NPAIR = NREQ / 2;

  for (genvar b = 0; b < DW; b++) begin : g_bit
    logic [NPAIR-1:0] aoi;
    // Each AOI22 yields the inverted OR of two gated slices.
    for (genvar k = 0; k < NPAIR; k++) begin : g_pair
      assign aoi[k] = ~((d[(2*k)*DW + b]   & g[2*k]) |
                        (d[(2*k+1)*DW + b] & g[2*k+1]));
    end
    // NAND of the inverted pair terms restores the positive OR.
    assign y[b] = ~(&aoi);
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin owner selection for one shared DW-bit bus.
// Ports: CK clock, RN async active-low reset, bus (slave modport) carrying
//   req/data_in in and gnt/gnt_id/bus_valid/bus_out out.
// A one-cycle TURN gap separates every pair of owners; MAX_HOLD bounds tenure.
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             CK,
  input  logic             RN,
  rr_bus_arbiter_if.slave  bus
);
  localparam int unsigned IDW = id_width(NREQ);
  localparam int unsigned HCW = hold_width(MAX_HOLD);

  arb_state_e     state;
  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hold_cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic           bus_valid;

  logic           found_c;
  logic [IDW-1:0] winner_c;
  logic           own_req_c;
  logic           preempt_c;

  // Rotating priority scan starting at ptr.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found_c && bus.req[IDW'((32'(ptr) + k) % NREQ)]) begin
        found_c  = 1'b1;
        winner_c = IDW'((32'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    own_req_c = bus.req[gnt_id];
    preempt_c = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD - 1));
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      bus_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (found_c) begin
            state     <= GRANT;
            gnt       <= NREQ'(1) << winner_c;
            gnt_id    <= winner_c;
            hold_cnt  <= '0;
            bus_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (own_req_c && (hold_cnt != '1)) hold_cnt <= hold_cnt + HCW'(1);
          // Release takes priority over preemption; both leave via TURN.
          if (!own_req_c || preempt_c) begin
            state     <= TURN;
            gnt       <= '0;
            bus_valid <= 1'b0;
            ptr       <= IDW'((32'(gnt_id) + 1) % NREQ);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_id    = gnt_id;
  assign bus.bus_valid = bus_valid;

  aoi_grant_mux #(.NREQ(NREQ), .DW(DW)) u_mux (
    .d (bus.data_in),
    .g (gnt),
    .y (bus.bus_out)
  );
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against an owner/pointer reference model.
module tb_rr_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 4;

  logic CK;
  logic RN;

  rr_bus_arbiter_if #(.NREQ(N), .DW(DW)) ifc ();

  rr_bus_arbiter #(.NREQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (ifc.slave)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how long, and where the scan starts.
  int m_owner;
  int m_hold;
  int m_ptr;
  int m_id;
  logic [N-1:0] prev_gnt;

  logic [N-1:0]    req_v;
  logic [N*DW-1:0] data_v;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_hold   = 0;
    m_ptr    = 0;
    m_id     = 0;
    prev_gnt = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!bit'(r >> m_owner) || (MH != 0 && m_hold == MH - 1)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bit'(r >> ((m_ptr + k) % N))) begin
          m_owner = (m_ptr + k) % N;
          m_id    = m_owner;
          m_hold  = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_bus;
    e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e_bus = (m_owner >= 0) ? DW'(data_v >> (m_owner * DW)) : '0;
    chk("gnt",       32'(ifc.gnt),       32'(e_gnt));
    chk("gnt_id",    32'(ifc.gnt_id),    32'(m_id));
    chk("bus_valid", 32'(ifc.bus_valid), 32'(m_owner >= 0));
    chk("bus_out",   32'(ifc.bus_out),   32'(e_bus));
    chk("onehot0",   32'($onehot0(ifc.gnt)), 32'd1);
    chk("valid_eq_or", 32'(ifc.bus_valid), 32'(|ifc.gnt));
    chk("no_direct_switch",
        32'((prev_gnt != '0) && (ifc.gnt != '0) && (prev_gnt != ifc.gnt)), 32'd0);
    prev_gnt = ifc.gnt;
  endtask

  // One clock: inputs already driven while CK is low.
  task automatic step();
    ifc.req     = req_v;
    ifc.data_in = data_v;
    @(posedge CK);
    model_step(req_v);
    @(negedge CK);
    compare_all();
  endtask

  logic [N-1:0] seq3 [11];

  initial begin
    RN     = 1'b0;
    req_v  = 4'b1111;
    data_v = {$urandom(), $urandom()} >> 32;
    ifc.req     = req_v;
    ifc.data_in = data_v;
    model_reset();

    // Reset holds everything off even with all requests active.
    repeat (2) @(negedge CK);
    chk("rst_gnt",    32'(ifc.gnt),       32'd0);
    chk("rst_bus",    32'(ifc.bus_out),   32'd0);
    chk("rst_valid",  32'(ifc.bus_valid), 32'd0);
    chk("rst_gnt_id", 32'(ifc.gnt_id),    32'd0);
    RN = 1'b1;
    step();
    chk("t1_first_gnt", 32'(ifc.gnt), 32'b0001);
    req_v = '0; step(); step();

    // Round robin between requesters 1 and 3.
    req_v = 4'b1010; step(); chk("t2_a", 32'(ifc.gnt), 32'b0010);
    step();                  chk("t2_b", 32'(ifc.gnt), 32'b0010);
    req_v = 4'b1000; step(); chk("t2_gap1", 32'(ifc.gnt), 32'b0000);
    req_v = 4'b1010; step(); chk("t2_c", 32'(ifc.gnt), 32'b1000);
    step();                  chk("t2_d", 32'(ifc.gnt), 32'b1000);
    req_v = 4'b0010; step(); chk("t2_gap2", 32'(ifc.gnt), 32'b0000);
    req_v = 4'b1010; step(); chk("t2_e", 32'(ifc.gnt), 32'b0010);
    req_v = '0; step(); step();

    // Preemption after MAX_HOLD cycles, alternating 0 and 1.
    seq3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
    req_v = 4'b0011;
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("t3_preempt_%0d", i), 32'(ifc.gnt), 32'(seq3[i]));
    end
    req_v = '0; step(); step();

    // Data steering for owner 2, then zero during the gap.
    data_v = {8'hFF, 8'hA5, 8'hFF, 8'hFF};
    req_v  = 4'b0100; step();
    chk("t4_gnt", 32'(ifc.gnt), 32'b0100);
    chk("t4_bus", 32'(ifc.bus_out), 32'hA5);
    req_v = '0; step();
    chk("t4_turn_bus", 32'(ifc.bus_out), 32'h00);
    step();

    // Asynchronous reset in the middle of a grant.
    req_v = 4'b1000; step();
    chk("t5_gnt", 32'(ifc.gnt), 32'b1000);
    #2 RN = 1'b0;
    #1;
    chk("t5_async_gnt",   32'(ifc.gnt),       32'd0);
    chk("t5_async_valid", 32'(ifc.bus_valid), 32'd0);
    model_reset();
    @(negedge CK);
    RN    = 1'b1;
    req_v = 4'b1001; step();
    chk("t5_ptr_reset", 32'(ifc.gnt), 32'b0001);
    req_v = '0; step(); step();

    // Random traffic; requests tend to persist to exercise holds and preemption.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3) req_v = N'($urandom());
      data_v = {$urandom(), $urandom()} >> 32;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
